// File: rtl/writeback_stage.sv
// Writeback stage of the 3-stage RISC-V lab CPU: WB pipeline register, register file,
// GPIO output register and retired-instruction counter. Define WB_FORWARD_EN to bypass WB data to the read ports.
module writeback_stage #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_EX,
  input  logic            flush_EX,
  input  logic            regwrite_EX,
  input  logic [1:0]      regsel_EX,
  input  logic            gpio_we_EX,
  input  logic [4:0]      rd_EX,
  input  logic [XLEN-1:0] alu_result_EX,
  input  logic [19:0]     imm20_EX,
  input  logic [XLEN-1:0] gpio_wdata_EX,
  input  logic [XLEN-1:0] gpio_in,
  input  logic [4:0]      readaddr1,
  input  logic [4:0]      readaddr2,
  output logic [XLEN-1:0] readdata1,
  output logic [XLEN-1:0] readdata2,
  output logic [XLEN-1:0] gpio_out,
  output logic [31:0]     instret
);

  logic            valid_WB;
  logic            regwrite_WB;
  logic            gpio_we_WB;
  logic [1:0]      regsel_WB;
  logic [4:0]      rd_WB;
  logic [XLEN-1:0] alu_result_WB;
  logic [19:0]     imm20_WB;
  logic [XLEN-1:0] gpio_wdata_WB;
  logic [XLEN-1:0] gpio_in_WB;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] wdata;
  logic            commit_rd;
  logic            live_EX;

  assign live_EX = valid_EX & ~flush_EX;

  // Squashed or empty slots carry no write enables, so a bubble can never commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_WB      <= 1'b0;
      regwrite_WB   <= 1'b0;
      gpio_we_WB    <= 1'b0;
      regsel_WB     <= '0;
      rd_WB         <= '0;
      alu_result_WB <= '0;
      imm20_WB      <= '0;
      gpio_wdata_WB <= '0;
      gpio_in_WB    <= '0;
    end else begin
      valid_WB      <= live_EX;
      regwrite_WB   <= regwrite_EX & live_EX;
      gpio_we_WB    <= gpio_we_EX & live_EX;
      regsel_WB     <= regsel_EX;
      rd_WB         <= rd_EX;
      alu_result_WB <= alu_result_EX;
      imm20_WB      <= imm20_EX;
      gpio_wdata_WB <= gpio_wdata_EX;
      gpio_in_WB    <= gpio_in;
    end
  end

  always_comb begin
    wdata = '0;
    case (regsel_WB)
      2'b00:   wdata = gpio_in_WB;
      2'b01:   wdata = {imm20_WB, 12'b0};
      2'b10:   wdata = alu_result_WB;
      default: wdata = '0;
    endcase
  end

  assign commit_rd = valid_WB & regwrite_WB & (rd_WB != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit_rd) begin
      regs[rd_WB] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= '0;
      instret  <= '0;
    end else begin
      if (valid_WB & gpio_we_WB) gpio_out <= gpio_wdata_WB;
      if (valid_WB) instret <= instret + 32'd1;
    end
  end

  always_comb begin
    readdata1 = '0;
    if (readaddr1 != 5'd0) begin
      readdata1 = regs[readaddr1];
`ifdef WB_FORWARD_EN
      if (commit_rd && readaddr1 == rd_WB) readdata1 = wdata;
`endif
    end
  end

  always_comb begin
    readdata2 = '0;
    if (readaddr2 != 5'd0) begin
      readdata2 = regs[readaddr2];
`ifdef WB_FORWARD_EN
      if (commit_rd && readaddr2 == rd_WB) readdata2 = wdata;
`endif
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: each issued slot is queued with its expected
// architectural effect and checked once it has committed.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_EX = 1'b0, flush_EX = 1'b0, regwrite_EX = 1'b0, gpio_we_EX = 1'b0;
  logic [1:0]  regsel_EX = '0;
  logic [4:0]  rd_EX = '0, readaddr1 = '0, readaddr2 = '0;
  logic [31:0] alu_result_EX = '0, gpio_wdata_EX = '0, gpio_in = '0;
  logic [19:0] imm20_EX = '0;
  logic [31:0] readdata1, readdata2, gpio_out, instret;

  writeback_stage #(.NREGS(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_EX(valid_EX), .flush_EX(flush_EX),
    .regwrite_EX(regwrite_EX), .regsel_EX(regsel_EX), .gpio_we_EX(gpio_we_EX),
    .rd_EX(rd_EX), .alu_result_EX(alu_result_EX), .imm20_EX(imm20_EX),
    .gpio_wdata_EX(gpio_wdata_EX), .gpio_in(gpio_in), .readaddr1(readaddr1),
    .readaddr2(readaddr2), .readdata1(readdata1), .readdata2(readdata2),
    .gpio_out(gpio_out), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic        gpio_we;
    logic [4:0]  rd;
    logic [31:0] wval;
    logic [31:0] gval;
    int          due;
  } entry_t;

  entry_t      sb_q[$];
  logic [31:0] model_regs [32];
  logic [31:0] model_gpio;
  logic [31:0] model_instret;
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_gpio    = '0;
    model_instret = '0;
    sb_q.delete();
  endtask

  // Advance one clock, then retire and check every slot whose commit edge has passed.
  task automatic tick();
    entry_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.valid) begin
        if (e.regwrite && e.rd != 5'd0) model_regs[e.rd] = e.wval;
        if (e.gpio_we) model_gpio = e.gval;
        model_instret = model_instret + 32'd1;
      end
      readaddr2 = e.rd;
      #1;
      check("sb_rd", readdata2, (e.rd == 5'd0) ? 32'h0 : model_regs[e.rd]);
      check("sb_gpio", gpio_out, model_gpio);
      check("sb_instret", instret, model_instret);
    end
  endtask

  task automatic issue(input logic v, input logic f, input logic rw, input logic [1:0] rs,
                       input logic gw, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [19:0] imm, input logic [31:0] gwd, input logic [31:0] gin);
    entry_t e;
    valid_EX = v; flush_EX = f; regwrite_EX = rw; regsel_EX = rs; gpio_we_EX = gw;
    rd_EX = rd; alu_result_EX = alu; imm20_EX = imm; gpio_wdata_EX = gwd; gpio_in = gin;
    e.valid    = v & ~f;
    e.regwrite = rw;
    e.gpio_we  = gw;
    e.rd       = rd;
    case (rs)
      2'b00:   e.wval = gin;
      2'b01:   e.wval = {imm, 12'h000};
      2'b10:   e.wval = alu;
      default: e.wval = 32'h0;
    endcase
    e.gval = gwd;
    e.due  = cyc + 2;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic bubble();
    issue(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset_model();

    // 1: reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      valid_EX = 1'b1; regwrite_EX = 1'b1; gpio_we_EX = 1'b1;
      regsel_EX = 2'($urandom_range(0, 3)); rd_EX = 5'($urandom_range(1, 31));
      alu_result_EX = $urandom; gpio_wdata_EX = $urandom; gpio_in = $urandom;
      imm20_EX = 20'($urandom);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      readaddr1 = 5'(i);
      readaddr2 = 5'(31 - i);
      #1;
      check("rst_rd1", readdata1, 32'h0);
      check("rst_rd2", readdata2, 32'h0);
    end
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_instret", instret, 32'h0);
    rst = 1'b0;
    issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd1, 32'h0000_0011, 20'h0, 32'h0, 32'h0);
    check("first_edge_instret", instret, 32'h0);
    readaddr1 = 5'd1;
    #1;
`ifndef WB_FORWARD_EN
    check("first_edge_reg1", readdata1, 32'h0);
`else
    check("first_edge_fwd1", readdata1, 32'h0000_0011);
`endif

    // 2: R-type writeback and forwarding window
    issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd5, 32'h1234_5678, 20'h0, 32'h0, 32'h0);
    readaddr1 = 5'd5;
    #1;
`ifdef WB_FORWARD_EN
    check("fwd_rd5", readdata1, 32'h1234_5678);
`else
    check("nofwd_rd5", readdata1, 32'h0);
`endif
    bubble();
    bubble();
    readaddr1 = 5'd5;
    #1;
    check("rtype_rd5", readdata1, 32'h1234_5678);
    check("rtype_instret", instret, 32'd2);

    // 3: LUI, then a discarded write to x0
    issue(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 5'd7, 32'h0, 20'hABCDE, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 32'hFFFF_FFFF, 20'h0, 32'h0, 32'h0);
    bubble();
    bubble();
    readaddr1 = 5'd7;
    readaddr2 = 5'd0;
    #1;
    check("lui_rd7", readdata1, 32'hABCD_E000);
    check("x0_zero", readdata2, 32'h0);
    check("x0_instret", instret, 32'd4);

    // 4: csrrw updates gpio_out and rd on the same edge
    issue(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 5'd3, 32'h0, 20'h0, 32'h0000_00FF, 32'h0000_0A5A);
    bubble();
    readaddr1 = 5'd3;
    #1;
    check("csr_gpio", gpio_out, 32'h0000_00FF);
    check("csr_rd3", readdata1, 32'h0000_0A5A);

    // 5: flushed and invalid slots must not commit
    issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd9, 32'h0000_9999, 20'h0, 32'h0, 32'h0);
    issue(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 5'd9, 32'hDEAD_BEEF, 20'h0, 32'h5555_5555, 32'h0);
    issue(1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 5'd9, 32'hDEAD_BEEF, 20'h0, 32'h5555_5555, 32'h0);
    bubble();
    bubble();
    readaddr1 = 5'd9;
    #1;
    check("flush_rd9", readdata1, 32'h0000_9999);
    check("flush_gpio", gpio_out, 32'h0000_00FF);
    check("flush_instret", instret, model_instret);

    // Back-to-back random traffic, including reserved regsel and flush mixes
    for (int k = 0; k < 40; k++) begin
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 1'($urandom),
            2'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 31)),
            $urandom, 20'($urandom), $urandom, $urandom);
    end
    bubble();
    bubble();

    // 6: counter wrap
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    model_instret = 32'hFFFF_FFFF;
    issue(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h0);
    bubble();
    check("wrap_instret", instret, 32'h0);

    // Asynchronous reset while rd=4 is pending in WB
    issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 5'd4, 32'h4444_4444, 20'h0, 32'h7777_7777, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    reset_model();
    readaddr1 = 5'd4;
    readaddr2 = 5'd5;
    #1;
    check("async_rd4", readdata1, 32'h0);
    check("async_rd5", readdata2, 32'h0);
    check("async_gpio", gpio_out, 32'h0);
    check("async_instret", instret, 32'h0);
    tick();
    readaddr1 = 5'd4;
    #1;
    check("held_rd4", readdata1, 32'h0);
    #2;
    rst = 1'b0;
    issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd6, 32'h0000_0666, 20'h0, 32'h0, 32'h0);
    bubble();
    bubble();
    readaddr1 = 5'd6;
    #1;
    check("post_rst_rd6", readdata1, 32'h0000_0666);
    check("post_rst_instret", instret, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
